llc_snoop_responder: RTL and testbench
======================================

Name: llc_snoop_responder

Overview:
- Snoop-side responder of the LLC; the counterpart of the LLC's own bus-operation initiator.
- Accepts bus operations broadcast by other caches and looks up the LLC tag/MESI array.
- Drives the snoop result (NOHIT/HIT/HITM), issues L2->L1 messages (GETLINE, INVALIDATELINE) and writes the next MESI state back to the array.
- Handles one snoop at a time under an FSM with valid/ready handshakes on every interface.

Parameters:
N_WAY, 16, ways per set
INDEX_SIZE, 14, set index bits
OFFSET_SIZE, 6, line offset bits
TAG_SIZE, 12, tag bits (32-INDEX_SIZE-OFFSET_SIZE)
MY_ID, 4'd0, this cache's id; snoops carrying this id are ignored

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
snp_req_valid  in  1  snooped bus op present
snp_req_ready  out  1  responder accepts op
snp_req_op  in  3  READ=001, WRITE=010, INVALIDATE=011, RWIM=100
snp_req_addr  in  32  snooped address
snp_req_id  in  4  initiating cache id
tag_rd_en  out  1  array read strobe
tag_rd_index  out  INDEX_SIZE  set to read
tag_rd_valid  in  N_WAY  per-way valid bits, valid one cycle after tag_rd_en
tag_rd_tag  in  N_WAY*TAG_SIZE  per-way tags, way w at [w*TAG_SIZE +: TAG_SIZE]
tag_rd_mesi  in  N_WAY*2  per-way MESI, I=00 S=01 E=10 M=11
tag_wr_en  out  1  MESI write strobe
tag_wr_index  out  INDEX_SIZE  set to write
tag_wr_way  out  $clog2(N_WAY)  way to write
tag_wr_mesi  out  2  new MESI state
l1_msg_valid  out  1  L1 message present
l1_msg_ready  in  1  L1 accepts message
l1_msg_type  out  2  GETLINE=01, INVALIDATELINE=11
l1_msg_addr  out  32  line address, offset bits zeroed
snp_rsp_valid  out  1  snoop result present
snp_rsp_ready  in  1  bus accepts result
snp_rsp_result  out  2  NOHIT=00, HIT=01, HITM=10
snp_rsp_addr  out  32  echo of snooped address
protocol_err  out  1  one-cycle pulse on illegal state

Behaviour:
- Reset: rst_n low at a clk edge forces FSM to IDLE and drops any in-flight snoop. While rst_n is low, every output is 0, including snp_req_ready.
- snp_req_ready = 1 only in IDLE with rst_n high. A request is accepted at the edge where valid&&ready (cycle T); addr, op and id are registered at T.
- Address split: index = addr[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE]; tag = addr[31:OFFSET_SIZE+INDEX_SIZE].
- States: IDLE, LOOKUP, EVAL, L1MSG, UPDATE, RESP.
- IDLE -> LOOKUP on accept. If snp_req_id==MY_ID, go IDLE -> RESP instead with NOHIT; no lookup is issued.
- LOOKUP (cycle T+1): tag_rd_en=1 for exactly one cycle, tag_rd_index=index. The array responds in T+2.
- EVAL (T+2), hit and way selection:
  - A way hits when valid && mesi!=I && tag match.
  - Select the lowest-numbered hitting way.
  - More than one hit: pulse protocol_err and use the lowest way.
- Action table, keyed by op and the hit way's state:
  - READ, M: HITM; GETLINE; next state S.
  - READ, E: HIT; no message; next state S.
  - READ, S: HIT; no change.
  - RWIM, M: HITM; GETLINE then INVALIDATELINE; next state I.
  - RWIM, E or S: HIT; INVALIDATELINE; next state I.
  - INVALIDATE, S: HIT; INVALIDATELINE; next state I.
  - INVALIDATE, E or M: protocol_err pulse; handled as the S case.
  - WRITE, any hit: NOHIT; no change; protocol_err pulse.
  - Any op, miss: NOHIT; no change.
  - Undefined op code: NOHIT; protocol_err pulse; no lookup side effects.
- EVAL next state: L1MSG if a message is needed, else UPDATE if the state changes, else RESP.
- L1MSG:
  - Holds l1_msg_valid with stable type/addr until l1_msg_ready.
  - A second message starts the cycle after the first handshake.
  - After the last handshake -> UPDATE.
- UPDATE: tag_wr_en=1 for exactly one cycle with index, way and new MESI, then -> RESP.
- RESP:
  - snp_rsp_valid held with stable result/addr until snp_rsp_ready, then -> IDLE.
  - The next request can be accepted the cycle after the response handshake.
- Latency with all readies high:
  - Own-id: snp_rsp_valid at T+1.
  - Miss or S-read hit: T+3.
  - READ E: T+4.
  - READ M or INVALIDATE S: T+5.
  - RWIM M: T+6.
- Backpressure stalls only the current state; no outputs change while stalled.
- Reset asserted in L1MSG or RESP abandons the snoop. UPDATE is a single cycle, so the write is either fully issued or not issued at all.

Test Plan:
- Reset with snp_req_valid=1 -> all outputs 0, no accept; after release snp_req_ready=1 the next cycle.
- READ 0x12345680, id=2, way 3 holds the tag in M -> GETLINE addr 0x12345680, tag_wr way 3 mesi=01, snp_rsp HITM at T+5.
- RWIM to the same line in E, with l1_msg_ready low for 3 cycles -> INVALIDATELINE held stable 4 cycles, write mesi=00, HIT at T+8.
- READ miss -> no tag_wr_en, no l1_msg_valid, NOHIT at T+3; snp_rsp_ready low 2 cycles -> result held, next accept after handshake.
- snp_req_id=MY_ID -> no tag_rd_en, NOHIT at T+1; WRITE hitting S -> NOHIT plus protocol_err pulse, MESI unchanged.
- Two ways (5, 9) matching in S under INVALIDATE -> protocol_err, way 5 written to I, HIT; rst_n low mid-L1MSG -> no tag_wr_en, FSM back in IDLE.

Source files
------------

// File: rtl/llc_snoop_if.sv
// Snoop-side bus bundle of the LLC: snooped request, tag/MESI array port,
// L2->L1 message channel and snoop response. slave = responder, master = environment.
interface llc_snoop_if #(
   parameter int N_WAY       = 16,
   parameter int INDEX_SIZE  = 14,
   parameter int OFFSET_SIZE = 6,
   parameter int TAG_SIZE    = 12
);
   localparam int WAY_W = $clog2(N_WAY);

   logic                      snp_req_valid;
   logic                      snp_req_ready;
   logic [2:0]                snp_req_op;
   logic [31:0]               snp_req_addr;
   logic [3:0]                snp_req_id;

   logic                      tag_rd_en;
   logic [INDEX_SIZE-1:0]     tag_rd_index;
   logic [N_WAY-1:0]          tag_rd_valid;
   logic [N_WAY*TAG_SIZE-1:0] tag_rd_tag;
   logic [N_WAY*2-1:0]        tag_rd_mesi;

   logic                      tag_wr_en;
   logic [INDEX_SIZE-1:0]     tag_wr_index;
   logic [WAY_W-1:0]          tag_wr_way;
   logic [1:0]                tag_wr_mesi;

   logic                      l1_msg_valid;
   logic                      l1_msg_ready;
   logic [1:0]                l1_msg_type;
   logic [31:0]               l1_msg_addr;

   logic                      snp_rsp_valid;
   logic                      snp_rsp_ready;
   logic [1:0]                snp_rsp_result;
   logic [31:0]               snp_rsp_addr;

   logic                      protocol_err;

   modport slave (
      input  snp_req_valid, snp_req_op, snp_req_addr, snp_req_id,
      output snp_req_ready,
      output tag_rd_en, tag_rd_index,
      input  tag_rd_valid, tag_rd_tag, tag_rd_mesi,
      output tag_wr_en, tag_wr_index, tag_wr_way, tag_wr_mesi,
      output l1_msg_valid, l1_msg_type, l1_msg_addr,
      input  l1_msg_ready,
      output snp_rsp_valid, snp_rsp_result, snp_rsp_addr,
      input  snp_rsp_ready,
      output protocol_err
   );

   modport master (
      output snp_req_valid, snp_req_op, snp_req_addr, snp_req_id,
      input  snp_req_ready,
      input  tag_rd_en, tag_rd_index,
      output tag_rd_valid, tag_rd_tag, tag_rd_mesi,
      input  tag_wr_en, tag_wr_index, tag_wr_way, tag_wr_mesi,
      input  l1_msg_valid, l1_msg_type, l1_msg_addr,
      output l1_msg_ready,
      input  snp_rsp_valid, snp_rsp_result, snp_rsp_addr,
      output snp_rsp_ready,
      input  protocol_err
   );
endinterface

// File: rtl/llc_snoop_responder.sv
// LLC snoop responder: looks up snooped bus ops in the tag/MESI array, answers
// NOHIT/HIT/HITM, issues L1 recalls/invalidates and writes back the next MESI state.
module llc_snoop_responder #(
   parameter int         N_WAY       = 16,
   parameter int         INDEX_SIZE  = 14,
   parameter int         OFFSET_SIZE = 6,
   parameter int         TAG_SIZE    = 12,
   parameter logic [3:0] MY_ID       = 4'd0
) (
   input logic        clk,
   input logic        rst_n,
   llc_snoop_if.slave bus_io
);
   localparam int WAY_W = $clog2(N_WAY);

   localparam logic [2:0] OP_READ  = 3'b001;
   localparam logic [2:0] OP_WRITE = 3'b010;
   localparam logic [2:0] OP_INVAL = 3'b011;
   localparam logic [2:0] OP_RWIM  = 3'b100;

   localparam logic [1:0] MESI_I = 2'b00;
   localparam logic [1:0] MESI_S = 2'b01;
   localparam logic [1:0] MESI_E = 2'b10;
   localparam logic [1:0] MESI_M = 2'b11;

   localparam logic [1:0] RES_NOHIT = 2'b00;
   localparam logic [1:0] RES_HIT   = 2'b01;
   localparam logic [1:0] RES_HITM  = 2'b10;

   localparam logic [1:0] MSG_GETLINE = 2'b01;
   localparam logic [1:0] MSG_INVAL   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_EVAL,
      ST_L1MSG,
      ST_UPDATE,
      ST_RESP
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [2:0]       op_q, op_d;
   logic [1:0]       result_q, result_d;
   logic [WAY_W-1:0] way_q, way_d;
   logic [1:0]       mesi_q, mesi_d;
   logic             getl_q, getl_d;
   logic             inval_q, inval_d;

   logic [INDEX_SIZE-1:0] snp_index;
   logic [TAG_SIZE-1:0]   snp_tag;
   logic                  op_known;

   assign snp_index = addr_q[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE];
   assign snp_tag   = addr_q[31:OFFSET_SIZE+INDEX_SIZE];
   assign op_known  = (op_q == OP_READ) || (op_q == OP_WRITE) ||
                      (op_q == OP_INVAL) || (op_q == OP_RWIM);

   logic [N_WAY-1:0] hit_vec;
   logic             hit_any;
   logic             hit_multi;
   logic [WAY_W-1:0] hit_way;
   logic [1:0]       hit_mesi;

   always_comb begin
      hit_vec  = '0;
      hit_way  = '0;
      hit_mesi = MESI_I;
      for (int w = 0; w < N_WAY; w++) begin
         hit_vec[w] = bus_io.tag_rd_valid[w] &&
                      (bus_io.tag_rd_mesi[w*2 +: 2] != MESI_I) &&
                      (bus_io.tag_rd_tag[w*TAG_SIZE +: TAG_SIZE] == snp_tag);
      end
      // Scan downward so the lowest-numbered hitting way wins.
      for (int w = N_WAY - 1; w >= 0; w--) begin
         if (hit_vec[w]) begin
            hit_way  = WAY_W'(w);
            hit_mesi = bus_io.tag_rd_mesi[w*2 +: 2];
         end
      end
      hit_any   = |hit_vec;
      hit_multi = (hit_vec & (hit_vec - N_WAY'(1))) != '0;
   end

   logic [1:0] act_result;
   logic       act_getl;
   logic       act_inval;
   logic       act_upd;
   logic [1:0] act_mesi;
   logic       act_err;

   always_comb begin
      act_result = RES_NOHIT;
      act_getl   = 1'b0;
      act_inval  = 1'b0;
      act_upd    = 1'b0;
      act_mesi   = hit_mesi;
      act_err    = 1'b0;
      if (!op_known) begin
         act_err = 1'b1;
      end else if (hit_any) begin
         act_err = hit_multi;
         case (op_q)
            OP_READ: begin
               act_result = (hit_mesi == MESI_M) ? RES_HITM : RES_HIT;
               act_getl   = (hit_mesi == MESI_M);
               act_upd    = (hit_mesi != MESI_S);
               act_mesi   = MESI_S;
            end
            OP_RWIM: begin
               act_result = (hit_mesi == MESI_M) ? RES_HITM : RES_HIT;
               act_getl   = (hit_mesi == MESI_M);
               act_inval  = 1'b1;
               act_upd    = 1'b1;
               act_mesi   = MESI_I;
            end
            OP_INVAL: begin
               // E/M under INVALIDATE is illegal but still treated as a shared line.
               act_result = RES_HIT;
               act_inval  = 1'b1;
               act_upd    = 1'b1;
               act_mesi   = MESI_I;
               if (hit_mesi != MESI_S) act_err = 1'b1;
            end
            OP_WRITE: begin
               act_err = 1'b1;
            end
            default: ;
         endcase
      end
   end

   logic       req_ready;
   logic       rd_en;
   logic       wr_en;
   logic       msg_valid;
   logic [1:0] msg_type;
   logic       rsp_valid;
   logic       err_pulse;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      op_d      = op_q;
      result_d  = result_q;
      way_d     = way_q;
      mesi_d    = mesi_q;
      getl_d    = getl_q;
      inval_d   = inval_q;
      req_ready = 1'b0;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      msg_valid = 1'b0;
      msg_type  = 2'b00;
      rsp_valid = 1'b0;
      err_pulse = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (bus_io.snp_req_valid) begin
               addr_d = bus_io.snp_req_addr;
               op_d   = bus_io.snp_req_op;
               if (bus_io.snp_req_id == MY_ID) begin
                  result_d = RES_NOHIT;
                  state_d  = ST_RESP;
               end else begin
                  state_d = ST_LOOKUP;
               end
            end
         end
         ST_LOOKUP: begin
            rd_en   = op_known;
            state_d = ST_EVAL;
         end
         ST_EVAL: begin
            err_pulse = act_err;
            result_d  = act_result;
            way_d     = hit_way;
            mesi_d    = act_mesi;
            getl_d    = act_getl;
            inval_d   = act_inval;
            if (act_getl || act_inval) state_d = ST_L1MSG;
            else if (act_upd)          state_d = ST_UPDATE;
            else                       state_d = ST_RESP;
         end
         ST_L1MSG: begin
            // GETLINE always precedes INVALIDATELINE when both are pending.
            msg_valid = 1'b1;
            msg_type  = getl_q ? MSG_GETLINE : MSG_INVAL;
            if (bus_io.l1_msg_ready) begin
               if (getl_q && inval_q) getl_d  = 1'b0;
               else                   state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            wr_en   = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (bus_io.snp_rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         getl_q  <= 1'b0;
         inval_q <= 1'b0;
      end else begin
         state_q <= state_d;
         getl_q  <= getl_d;
         inval_q <= inval_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q   <= addr_d;
      op_q     <= op_d;
      result_q <= result_d;
      way_q    <= way_d;
      mesi_q   <= mesi_d;
   end

   // Every output is forced low while reset is held, independent of state.
   assign bus_io.snp_req_ready  = rst_n & req_ready;
   assign bus_io.tag_rd_en      = rst_n & rd_en;
   assign bus_io.tag_rd_index   = rst_n ? snp_index : '0;
   assign bus_io.tag_wr_en      = rst_n & wr_en;
   assign bus_io.tag_wr_index   = rst_n ? snp_index : '0;
   assign bus_io.tag_wr_way     = rst_n ? way_q : '0;
   assign bus_io.tag_wr_mesi    = rst_n ? mesi_q : '0;
   assign bus_io.l1_msg_valid   = rst_n & msg_valid;
   assign bus_io.l1_msg_type    = rst_n ? msg_type : '0;
   assign bus_io.l1_msg_addr    = rst_n ? {addr_q[31:OFFSET_SIZE], {OFFSET_SIZE{1'b0}}} : '0;
   assign bus_io.snp_rsp_valid  = rst_n & rsp_valid;
   assign bus_io.snp_rsp_result = rst_n ? result_q : '0;
   assign bus_io.snp_rsp_addr   = rst_n ? addr_q : '0;
   assign bus_io.protocol_err   = rst_n & err_pulse;
endmodule

// File: tb/tb_llc_snoop_responder.sv
// Bench for llc_snoop_responder: a behavioural tag/MESI array plus a rule-level
// model of the snoop protocol; directed scenarios followed by random snoops.
module tb_llc_snoop_responder;
   localparam int N_WAY       = 16;
   localparam int INDEX_SIZE  = 14;
   localparam int OFFSET_SIZE = 6;
   localparam int TAG_SIZE    = 12;
   localparam int MY_ID       = 0;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   llc_snoop_if #(.N_WAY(N_WAY), .INDEX_SIZE(INDEX_SIZE), .OFFSET_SIZE(OFFSET_SIZE),
                  .TAG_SIZE(TAG_SIZE)) bus ();

   llc_snoop_responder #(.N_WAY(N_WAY), .INDEX_SIZE(INDEX_SIZE), .OFFSET_SIZE(OFFSET_SIZE),
                         .TAG_SIZE(TAG_SIZE), .MY_ID(4'd0)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   // Array contents keyed by set*N_WAY+way; absent keys are invalid ways.
   bit        a_val  [int];
   bit [1:0]  a_mesi [int];
   bit [11:0] a_tag  [int];

   // Model expectations for the current snoop.
   bit        e_rd, e_err, e_wr;
   bit [1:0]  e_res, e_mesi;
   int        e_way, e_lat;
   bit [1:0]  e_msgs[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int key(input int idx, input int w);
      return idx * N_WAY + w;
   endfunction

   task automatic put_line(input int idx, input int w, input bit v, input bit [1:0] m, input bit [11:0] t);
      a_val[key(idx, w)]  = v;
      a_mesi[key(idx, w)] = m;
      a_tag[key(idx, w)]  = t;
   endtask

   task automatic clear_set(input int idx);
      for (int w = 0; w < N_WAY; w++) put_line(idx, w, 1'b0, 2'b00, 12'h000);
   endtask

   function automatic bit outs_any();
      return |{bus.snp_req_ready, bus.tag_rd_en, bus.tag_rd_index, bus.tag_wr_en, bus.tag_wr_index,
               bus.tag_wr_way, bus.tag_wr_mesi, bus.l1_msg_valid, bus.l1_msg_type, bus.l1_msg_addr,
               bus.snp_rsp_valid, bus.snp_rsp_result, bus.snp_rsp_addr, bus.protocol_err};
   endfunction

   task automatic drive_rd(input int idx);
      logic [N_WAY-1:0]          v;
      logic [N_WAY*TAG_SIZE-1:0] t;
      logic [N_WAY*2-1:0]        m;
      for (int w = 0; w < N_WAY; w++) begin
         int k = key(idx, w);
         v[w]                      = a_val.exists(k) ? a_val[k] : 1'b0;
         t[w*TAG_SIZE +: TAG_SIZE] = a_tag.exists(k) ? a_tag[k] : 12'h000;
         m[w*2 +: 2]               = a_mesi.exists(k) ? a_mesi[k] : 2'b00;
      end
      bus.tag_rd_valid = v;
      bus.tag_rd_tag   = t;
      bus.tag_rd_mesi  = m;
   endtask

   // Protocol rules: MESI 0=I 1=S 2=E 3=M; results 0 NOHIT 1 HIT 2 HITM; msgs 1 GETLINE 3 INVAL.
   task automatic model(input bit [2:0] op, input bit [31:0] addr, input bit [3:0] id, input int l1_stall);
      int idx, tg, nh, first;
      bit [1:0] st;
      e_rd = 0; e_err = 0; e_wr = 0; e_res = 0; e_mesi = 0; e_way = 0;
      e_msgs.delete();
      idx = int'(addr >> OFFSET_SIZE) % (1 << INDEX_SIZE);
      tg  = int'(addr >> (OFFSET_SIZE + INDEX_SIZE));
      if (id == MY_ID) begin
         e_lat = 1;
         return;
      end
      e_lat = 3;
      if (op < 1 || op > 4) begin
         e_err = 1;
         return;
      end
      e_rd = 1; nh = 0; first = -1;
      for (int w = 0; w < N_WAY; w++) begin
         int k = key(idx, w);
         if (a_val.exists(k) && a_val[k] && a_mesi[k] != 0 && int'(a_tag[k]) == tg) begin
            nh++;
            if (first < 0) first = w;
         end
      end
      if (nh > 0) begin
         st    = a_mesi[key(idx, first)];
         e_err = (nh > 1);
         e_way = first;
         case (op)
            3'd1: begin
               e_res = (st == 3) ? 2 : 1;
               if (st == 3) e_msgs.push_back(2'd1);
               e_wr = (st != 1); e_mesi = 1;
            end
            3'd4: begin
               e_res = (st == 3) ? 2 : 1;
               if (st == 3) e_msgs.push_back(2'd1);
               e_msgs.push_back(2'd3);
               e_wr = 1; e_mesi = 0;
            end
            3'd3: begin
               e_res = 1; e_msgs.push_back(2'd3);
               e_wr = 1; e_mesi = 0;
               if (st != 1) e_err = 1;
            end
            default: e_err = 1;
         endcase
      end
      e_lat = 3 + e_msgs.size() + (e_wr ? 1 : 0) + ((e_msgs.size() > 0) ? l1_stall : 0);
   endtask

   task automatic run_snoop(input string nm, input bit [2:0] op, input bit [31:0] addr, input bit [3:0] id,
                            input int l1_stall, input int rsp_stall, input int abort_at);
      int cyc, l1_left, rsp_left, rd_idx, rd_cnt, wr_cnt, err_cnt, l1_cyc, rsp_cyc, lat, unstable;
      int wr_idx, wr_way;
      bit [1:0] wr_mesi, res, pl1_t;
      bit [31:0] raddr, pl1_a;
      bit rd_pend, done, aborted, l1_hold, rsp_seen;
      bit [1:0] o_types[$];
      bit [31:0] o_addrs[$];
      model(op, addr, id, l1_stall);
      cyc = 0; rd_pend = 0; done = 0; aborted = 0; l1_hold = 0; rsp_seen = 0;
      rd_cnt = 0; wr_cnt = 0; err_cnt = 0; l1_cyc = 0; rsp_cyc = 0; lat = 0; unstable = 0;
      wr_idx = 0; wr_way = 0; wr_mesi = 0; res = 0; raddr = 0; pl1_t = 0; pl1_a = 0; rd_idx = 0;
      l1_left = l1_stall; rsp_left = rsp_stall;
      @(negedge clk);
      chk({nm, ".req_ready"}, bus.snp_req_ready, 1'b1);
      bus.snp_req_valid = 1'b1; bus.snp_req_op = op; bus.snp_req_addr = addr; bus.snp_req_id = id;
      bus.l1_msg_ready  = (l1_left == 0);
      bus.snp_rsp_ready = (rsp_left == 0);
      while (!done && cyc < 60) begin
         @(posedge clk); #1;
         if (rd_pend) begin drive_rd(rd_idx); rd_pend = 0; end
         else bus.tag_rd_valid = '0;
         @(negedge clk);
         cyc++;
         bus.snp_req_valid = 1'b0;
         if (bus.tag_rd_en) begin rd_cnt++; rd_pend = 1; rd_idx = int'(bus.tag_rd_index); end
         if (bus.tag_wr_en) begin
            wr_cnt++; wr_idx = int'(bus.tag_wr_index); wr_way = int'(bus.tag_wr_way); wr_mesi = bus.tag_wr_mesi;
            a_mesi[key(wr_idx, wr_way)] = wr_mesi;
         end
         if (bus.protocol_err) err_cnt++;
         if (bus.l1_msg_valid) begin
            l1_cyc++;
            if (l1_hold && (bus.l1_msg_type != pl1_t || bus.l1_msg_addr != pl1_a)) unstable++;
            pl1_t = bus.l1_msg_type; pl1_a = bus.l1_msg_addr;
            if (l1_left > 0) begin bus.l1_msg_ready = 1'b0; l1_left--; l1_hold = 1; end
            else begin
               bus.l1_msg_ready = 1'b1; l1_hold = 0;
               o_types.push_back(pl1_t); o_addrs.push_back(pl1_a);
            end
         end
         if (bus.snp_rsp_valid) begin
            rsp_cyc++;
            if (!rsp_seen) begin lat = cyc; res = bus.snp_rsp_result; raddr = bus.snp_rsp_addr; rsp_seen = 1; end
            else if (bus.snp_rsp_result != res || bus.snp_rsp_addr != raddr) unstable++;
            if (rsp_left > 0) begin bus.snp_rsp_ready = 1'b0; rsp_left--; end
            else begin bus.snp_rsp_ready = 1'b1; done = 1; end
         end
         if (abort_at > 0 && l1_cyc == abort_at) begin rst_n = 1'b0; aborted = 1; done = 1; end
      end
      chk({nm, ".completed"}, done, 1'b1);
      if (aborted) begin
         @(negedge clk);
         bus.tag_rd_valid = '0;
         chk({nm, ".outs_in_reset"}, outs_any(), 1'b0);
         chk({nm, ".no_write"}, wr_cnt, 0);
         rst_n = 1'b1; bus.l1_msg_ready = 1'b1;
         @(negedge clk);
         chk({nm, ".idle_after_reset"}, bus.snp_req_ready, 1'b1);
         chk({nm, ".no_write_after"}, bus.tag_wr_en, 1'b0);
         return;
      end
      chk({nm, ".result"}, res, e_res);
      chk({nm, ".rsp_addr"}, raddr, addr);
      chk({nm, ".latency"}, lat, e_lat);
      chk({nm, ".rd_count"}, rd_cnt, e_rd);
      chk({nm, ".wr_count"}, wr_cnt, e_wr);
      if (e_wr) begin
         chk({nm, ".wr_index"}, wr_idx, int'(addr >> OFFSET_SIZE) % (1 << INDEX_SIZE));
         chk({nm, ".wr_way"}, wr_way, e_way);
         chk({nm, ".wr_mesi"}, wr_mesi, e_mesi);
      end
      chk({nm, ".msg_count"}, o_types.size(), e_msgs.size());
      for (int i = 0; i < e_msgs.size() && i < o_types.size(); i++) begin
         chk({nm, ".msg_type"}, o_types[i], e_msgs[i]);
         chk({nm, ".msg_addr"}, o_addrs[i], addr & 32'hFFFF_FFC0);
      end
      chk({nm, ".l1_cycles"}, l1_cyc, e_msgs.size() + ((e_msgs.size() > 0) ? l1_stall : 0));
      chk({nm, ".rsp_cycles"}, rsp_cyc, 1 + rsp_stall);
      chk({nm, ".err_pulses"}, err_cnt, e_err);
      chk({nm, ".stable"}, unstable, 0);
      @(posedge clk); #1;
      bus.tag_rd_valid = '0;
      @(negedge clk);
      chk({nm, ".next_accept"}, bus.snp_req_ready, 1'b1);
      bus.l1_msg_ready = 1'b1; bus.snp_rsp_ready = 1'b1;
   endtask

   initial begin
      int idx_a, idx_b, rset[4];
      bit [11:0] pool[24];
      bit [31:0] a;
      bus.snp_req_valid = 1'b1; bus.snp_req_op = 3'b001; bus.snp_req_addr = 32'h0BAD_0040;
      bus.snp_req_id = 4'd2; bus.tag_rd_valid = '0; bus.tag_rd_tag = '0; bus.tag_rd_mesi = '0;
      bus.l1_msg_ready = 1'b1; bus.snp_rsp_ready = 1'b1;
      rst_n = 1'b0;

      // Reset held with a request pending: nothing may be accepted or driven.
      repeat (3) @(negedge clk);
      chk("reset.outs_zero", outs_any(), 1'b0);
      @(negedge clk);
      chk("reset.outs_zero2", outs_any(), 1'b0);
      rst_n = 1'b1; bus.snp_req_valid = 1'b0;
      @(negedge clk);
      chk("reset.ready_after", bus.snp_req_ready, 1'b1);
      chk("reset.no_lookup", bus.tag_rd_en, 1'b0);

      idx_a = int'(32'h1234_5680 >> OFFSET_SIZE) % (1 << INDEX_SIZE);
      clear_set(idx_a);
      put_line(idx_a, 3, 1'b1, 2'b11, 12'h123);
      run_snoop("read_m", 3'b001, 32'h1234_5680, 4'd2, 0, 0, 0);
      chk("read_m.array_now_s", a_mesi[key(idx_a, 3)], 2'b01);

      put_line(idx_a, 3, 1'b1, 2'b10, 12'h123);
      run_snoop("rwim_e_stall", 3'b100, 32'h1234_5680, 4'd1, 3, 0, 0);
      chk("rwim_e.array_now_i", a_mesi[key(idx_a, 3)], 2'b00);

      run_snoop("read_miss", 3'b001, 32'h4564_5680, 4'd3, 0, 2, 0);
      run_snoop("own_id", 3'b001, 32'h1234_5680, 4'd0, 0, 0, 0);

      put_line(idx_a, 3, 1'b1, 2'b01, 12'h123);
      run_snoop("write_hit_s", 3'b010, 32'h1234_5680, 4'd2, 0, 0, 0);
      chk("write_hit_s.array_kept", a_mesi[key(idx_a, 3)], 2'b01);

      idx_b = 14'h0A5C;
      clear_set(idx_b);
      put_line(idx_b, 5, 1'b1, 2'b01, 12'h7E1);
      put_line(idx_b, 9, 1'b1, 2'b01, 12'h7E1);
      run_snoop("multi_hit", 3'b011, {12'h7E1, 14'h0A5C, 6'h11}, 4'd1, 0, 0, 0);
      chk("multi_hit.way9_kept", a_mesi[key(idx_b, 9)], 2'b01);

      run_snoop("undef_op", 3'b111, {12'h7E1, 14'h0A5C, 6'h00}, 4'd1, 0, 0, 0);

      put_line(idx_a, 7, 1'b1, 2'b11, 12'h321);
      run_snoop("reset_in_l1msg", 3'b001, 32'h3214_5680, 4'd2, 10, 0, 2);
      chk("reset_in_l1msg.array_kept", a_mesi[key(idx_a, 7)], 2'b11);

      // Random snoops over a few populated sets drawing tags from a small pool.
      for (int i = 0; i < 24; i++) pool[i] = 12'($urandom);
      for (int s = 0; s < 4; s++) begin
         rset[s] = int'($urandom_range(0, (1 << INDEX_SIZE) - 1));
         for (int w = 0; w < N_WAY; w++)
            put_line(rset[s], w, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                     pool[$urandom_range(0, 23)]);
      end
      for (int n = 0; n < 40; n++) begin
         bit [2:0] op;
         bit [11:0] t;
         t  = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 23)] : 12'($urandom);
         a  = {t, 14'(rset[$urandom_range(0, 3)]), 6'($urandom)};
         op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
         run_snoop($sformatf("rand%0d", n), op, a, 4'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
